// File: rtl/disp_source_ctrl.sv
// Display source controller: picks one of five CPU observation buses with two
// debounced push-buttons and samples it into a registered display word at a
// fixed refresh rate. A freeze level holds the displayed word.

// Per-button front end: 2-flop synchronizer, stability counter, press pulse.
module disp_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count while the synchronized level differs; accept it after a full window.
  always_comb begin
    cnt_d   = '0;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d   = sync2_q;
        press_d = sync2_q;   // only the rising debounced edge is a press
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer, debounce state and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;
endmodule

module disp_source_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 5000000,
  parameter int CNT_W           = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_out,
  input  logic [31:0] reg_rdata,
  input  logic [31:0] mem_rdata,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        freeze,
  output logic [31:0] dout,
  output logic [2:0]  src_sel,
  output logic        sample_tick
);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [1:0]       btn_raw, press;   // [0]=next, [1]=prev
  logic [2:0]       sel_q, sel_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic             tick_q, tick_d;
  logic [31:0]      dout_q, dout_d;
  logic [31:0]      mux_val;

  assign btn_raw = {btn_prev, btn_next};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    disp_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_raw[b]),
      .press_o(press[b])
    );
  end

  // Step the selection with wrap; simultaneous presses cancel out.
  always_comb begin
    sel_d = sel_q;
    if (press[0] && !press[1])
      sel_d = (sel_q >= 3'd4) ? 3'd0 : sel_q + 3'd1;
    else if (press[1] && !press[0])
      sel_d = (sel_q == 3'd0) ? 3'd4 : sel_q - 3'd1;
    chg_d = (sel_d != sel_q);
  end

  // Source mux; indices 5..7 cannot be reached but read as zero.
  always_comb begin
    case (sel_q)
      3'd0:    mux_val = pc;
      3'd1:    mux_val = instr;
      3'd2:    mux_val = alu_out;
      3'd3:    mux_val = reg_rdata;
      3'd4:    mux_val = mem_rdata;
      default: mux_val = 32'h0;
    endcase
  end

  // Refresh timing and display load: freeze, then selection change, then tick.
  // A change seen while frozen is dropped so unfreezing never forces a load.
  always_comb begin
    ref_d  = (ref_q == REF_LAST) ? '0 : ref_q + CNT_W'(1);
    dout_d = dout_q;
    if (!freeze) begin
      if (chg_q) begin
        dout_d = mux_val;
        ref_d  = '0;
      end else if (tick_q) begin
        dout_d = mux_val;
      end
    end
    tick_d = (ref_d == REF_LAST);
  end

  // Output and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 3'd0;
      chg_q  <= 1'b0;
      ref_q  <= '0;
      tick_q <= 1'b0;
      dout_q <= 32'h0;
    end else begin
      sel_q  <= sel_d;
      chg_q  <= chg_d;
      ref_q  <= ref_d;
      tick_q <= tick_d;
      dout_q <= dout_d;
    end
  end

  assign dout        = dout_q;
  assign src_sel     = sel_q;
  assign sample_tick = tick_q;
endmodule

// File: tb/tb_disp_source_ctrl.sv
// Directed bench for disp_source_ctrl with DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8.
// Inputs change and outputs are sampled on the falling clock edge; "edge k"
// means the k-th rising edge after the most recent reset release.
module tb_disp_source_ctrl;
  localparam int DEB = 4;
  localparam int REF = 8;
  localparam logic [31:0] PC0  = 32'h0040_0010;
  localparam logic [31:0] PC1  = 32'h0040_0020;
  localparam logic [31:0] INS  = 32'h2008_0005;
  localparam logic [31:0] ALU0 = 32'hDEAD_BEEF;
  localparam logic [31:0] ALU1 = 32'hA5A5_0001;
  localparam logic [31:0] REG0 = 32'h1234_5678;
  localparam logic [31:0] MEM0 = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc, instr, alu_out, reg_rdata, mem_rdata;
  logic        btn_next, btn_prev, freeze;
  logic [31:0] dout;
  logic [2:0]  src_sel;
  logic        sample_tick;

  int checks = 0;
  int failures = 0;

  disp_source_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REFRESH_CYCLES (REF),
    .CNT_W          (26)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .instr      (instr),
    .alu_out    (alu_out),
    .reg_rdata  (reg_rdata),
    .mem_rdata  (mem_rdata),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .freeze     (freeze),
    .dout       (dout),
    .src_sel    (src_sel),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; freeze = 1'b0;
    pc = PC0; instr = INS; alu_out = ALU0; reg_rdata = REG0; mem_rdata = MEM0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // Clean press: raw high 8 cycles, low 8 cycles. Selection moves at raw+7.
  task automatic press(input logic prev);
    if (prev) btn_prev = 1'b1; else btn_next = 1'b1;
    cyc(8);
    btn_next = 1'b0; btn_prev = 1'b0;
    cyc(8);
  endtask

  task automatic test_reset;
    logic        exp_tick;
    logic [31:0] exp_dout;
    rst_n = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; freeze = 1'b0;
    pc = PC0; instr = INS; alu_out = ALU0; reg_rdata = REG0; mem_rdata = MEM0;
    cyc(2);
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout: got %h want 0", dout); end
    checks++; if (src_sel !== 3'd0) begin failures++; $display("FAIL reset_sel: got %0d want 0", src_sel); end
    checks++; if (sample_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b want 0", sample_tick); end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      exp_tick = (k == 7 || k == 15);
      exp_dout = (k >= 8) ? PC0 : 32'h0;
      checks++; if (sample_tick !== exp_tick) begin failures++; $display("FAIL first_tick k=%0d: got %b want %b", k, sample_tick, exp_tick); end
      checks++; if (dout !== exp_dout) begin failures++; $display("FAIL first_load k=%0d: got %h want %h", k, dout, exp_dout); end
      checks++; if (src_sel !== 3'd0) begin failures++; $display("FAIL idle_sel k=%0d: got %0d want 0", k, src_sel); end
    end
  endtask

  // Raw edge at neg 3: pulse edge 9, src_sel edge 10, reload edge 11,
  // refresh restarted so the next tick is at edge 18 instead of 15.
  task automatic test_next_hold;
    logic [2:0]  exp_sel;
    logic [31:0] exp_dout;
    logic        exp_tick;
    do_reset;
    cyc(3);
    btn_next = 1'b1;
    for (int k = 4; k <= 25; k++) begin
      cyc(1);
      if (k == 13) btn_next = 1'b0;
      exp_sel  = (k < 10) ? 3'd0 : 3'd1;
      exp_dout = (k < 8) ? 32'h0 : ((k < 11) ? PC0 : INS);
      exp_tick = (k == 7 || k == 18);
      checks++; if (src_sel !== exp_sel) begin failures++; $display("FAIL hold_sel k=%0d: got %0d want %0d", k, src_sel, exp_sel); end
      checks++; if (dout !== exp_dout) begin failures++; $display("FAIL hold_dout k=%0d: got %h want %h", k, dout, exp_dout); end
      checks++; if (sample_tick !== exp_tick) begin failures++; $display("FAIL hold_tick k=%0d: got %b want %b", k, sample_tick, exp_tick); end
    end
  endtask

  task automatic test_glitch_and_sequence;
    logic [2:0]  seq_sel  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [31:0] seq_dout [5] = '{INS, ALU0, REG0, MEM0, PC0};
    do_reset;
    cyc(3);
    btn_next = 1'b1;
    cyc(2);
    btn_next = 1'b0;
    cyc(15);
    checks++; if (src_sel !== 3'd0) begin failures++; $display("FAIL glitch_sel: got %0d want 0", src_sel); end
    checks++; if (dout !== PC0) begin failures++; $display("FAIL glitch_dout: got %h want %h", dout, PC0); end
    for (int i = 0; i < 5; i++) begin
      press(1'b0);
      checks++; if (src_sel !== seq_sel[i]) begin failures++; $display("FAIL seq_sel %0d: got %0d want %0d", i, src_sel, seq_sel[i]); end
      checks++; if (dout !== seq_dout[i]) begin failures++; $display("FAIL seq_dout %0d: got %h want %h", i, dout, seq_dout[i]); end
    end
    press(1'b1);
    checks++; if (src_sel !== 3'd4) begin failures++; $display("FAIL prev_wrap_sel: got %0d want 4", src_sel); end
    checks++; if (dout !== MEM0) begin failures++; $display("FAIL prev_wrap_dout: got %h want %h", dout, MEM0); end
  endtask

  // Both pulses at edge 15; ticks load at 8/16/24. pc changes after the
  // edge-16 load, so any spurious reload would show PC1 before edge 24.
  task automatic test_both;
    do_reset;
    cyc(9);
    btn_next = 1'b1; btn_prev = 1'b1;
    cyc(7);
    pc = PC1;
    btn_next = 1'b0; btn_prev = 1'b0;
    cyc(4);
    checks++; if (src_sel !== 3'd0) begin failures++; $display("FAIL both_sel: got %0d want 0", src_sel); end
    checks++; if (dout !== PC0) begin failures++; $display("FAIL both_noreload: got %h want %h", dout, PC0); end
    cyc(4);
    checks++; if (dout !== PC1) begin failures++; $display("FAIL both_tickload: got %h want %h", dout, PC1); end
    checks++; if (src_sel !== 3'd0) begin failures++; $display("FAIL both_sel_late: got %0d want 0", src_sel); end
  endtask

  task automatic test_freeze;
    int n;
    int ticks;
    do_reset;
    cyc(9);
    freeze = 1'b1;
    alu_out = ALU1;
    press(1'b0);
    checks++; if (src_sel !== 3'd1) begin failures++; $display("FAIL frz_sel1: got %0d want 1", src_sel); end
    checks++; if (dout !== PC0) begin failures++; $display("FAIL frz_hold1: got %h want %h", dout, PC0); end
    press(1'b0);
    checks++; if (src_sel !== 3'd2) begin failures++; $display("FAIL frz_sel2: got %0d want 2", src_sel); end
    ticks = 0;
    for (int k = 0; k < 24; k++) begin
      cyc(1);
      if (sample_tick === 1'b1) ticks++;
    end
    checks++; if (ticks != 3) begin failures++; $display("FAIL frz_ticks: got %0d want 3", ticks); end
    checks++; if (dout !== PC0) begin failures++; $display("FAIL frz_hold2: got %h want %h", dout, PC0); end
    n = 0;
    while (sample_tick !== 1'b1 && n < 20) begin cyc(1); n++; end
    checks++; if (sample_tick !== 1'b1) begin failures++; $display("FAIL frz_wait_tick1: got %b want 1 (timeout)", sample_tick); end
    cyc(1);
    freeze = 1'b0;
    cyc(1);
    checks++; if (dout !== PC0) begin failures++; $display("FAIL unfrz_noreload: got %h want %h", dout, PC0); end
    n = 0;
    while (sample_tick !== 1'b1 && n < 20) begin cyc(1); n++; end
    checks++; if (sample_tick !== 1'b1) begin failures++; $display("FAIL frz_wait_tick2: got %b want 1 (timeout)", sample_tick); end
    checks++; if (dout !== PC0) begin failures++; $display("FAIL unfrz_pretick: got %h want %h", dout, PC0); end
    cyc(1);
    checks++; if (dout !== ALU1) begin failures++; $display("FAIL unfrz_tickload: got %h want %h", dout, ALU1); end
  endtask

  // Reset lands with the debounce counter at 2; a fresh full window is needed.
  task automatic test_reset_mid;
    do_reset;
    cyc(3);
    press(1'b0);
    checks++; if (src_sel !== 3'd1) begin failures++; $display("FAIL mid_setup_sel: got %0d want 1", src_sel); end
    btn_next = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL mid_rst_dout: got %h want 0", dout); end
    checks++; if (src_sel !== 3'd0) begin failures++; $display("FAIL mid_rst_sel: got %0d want 0", src_sel); end
    checks++; if (sample_tick !== 1'b0) begin failures++; $display("FAIL mid_rst_tick: got %b want 0", sample_tick); end
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    checks++; if (src_sel !== 3'd0) begin failures++; $display("FAIL mid_early_sel: got %0d want 0", src_sel); end
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL mid_early_dout: got %h want 0", dout); end
    cyc(1);
    checks++; if (src_sel !== 3'd1) begin failures++; $display("FAIL mid_press_sel: got %0d want 1", src_sel); end
    cyc(1);
    checks++; if (dout !== INS) begin failures++; $display("FAIL mid_press_dout: got %h want %h", dout, INS); end
    btn_next = 1'b0;
    cyc(8);
  endtask

  initial begin
    btn_next = 1'b0; btn_prev = 1'b0; freeze = 1'b0;
    pc = PC0; instr = INS; alu_out = ALU0; reg_rdata = REG0; mem_rdata = MEM0;
    test_reset;
    test_next_hold;
    test_glitch_and_sequence;
    test_both;
    test_freeze;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
